// File: rtl/tetris_move_gen.sv
// ---------------------------------------------------------------------------
// tetris_move_gen
// Move-request generator for the falling piece. Debounces the raw left,
// right and down buttons, runs the level-dependent gravity timer and
// arbitrates both sources into single-cycle, mutually exclusive move pulses.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_left   raw asynchronous button, active-high
//   btn_right  raw asynchronous button, active-high
//   btn_down   raw asynchronous button, active-high (soft drop)
//   level      current game level 0..15
//   enable     game running; low clears and freezes move generation
//   busy       downstream cannot accept a move this cycle
//   drop       registered one-cycle pulse: move piece down one row
//   left       registered one-cycle pulse: move piece left one column
//   right      registered one-cycle pulse: move piece right one column
//
// Build option
//   TETRIS_AUTOREPEAT_EN  when defined, held left/right buttons auto-repeat
//                         after REP_DELAY cycles, then every REP_PERIOD.
// ---------------------------------------------------------------------------
module tetris_move_gen #(
   parameter int unsigned DB_CYC       = 16,
   parameter int unsigned GRAV_PERIOD0 = 1024,
   parameter int unsigned GRAV_STEP    = 64,
   parameter int unsigned GRAV_MIN     = 64,
   parameter int unsigned SOFT_PERIOD  = 32,
   parameter int unsigned REP_DELAY    = 128,
   parameter int unsigned REP_PERIOD   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_down,
   input  logic [3:0] level,
   input  logic       enable,
   input  logic       busy,
   output logic       drop,
   output logic       left,
   output logic       right
);

   localparam int unsigned PW  = 16;
   localparam int unsigned DBW = $clog2(DB_CYC);

   // Reject parameter sets the counters cannot represent.
   generate
      if (DB_CYC < 2 || REP_DELAY == 0 || REP_PERIOD == 0 || SOFT_PERIOD == 0 ||
          GRAV_MIN == 0 || GRAV_PERIOD0 < GRAV_MIN) begin : g_param_err
         $error("tetris_move_gen: illegal parameter set");
      end
   endgenerate

   // Button index: 0 = left, 1 = right, 2 = down.
   logic [2:0]     btn_raw;
   logic [2:0]     sync1;
   logic [2:0]     sync2;
   logic [2:0]     db;
   logic [2:0]     db_q;
   logic [DBW-1:0] db_cnt [3];
   logic [2:0]     press_c;
   logic [1:0]     rep_set_c;

   assign btn_raw = {btn_down, btn_right, btn_left};
   assign press_c = db & ~db_q;

   // Synchronizers and debouncers; these keep running while disabled so a
   // button held across the enable rise never looks like a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != db[i]) begin
               if (db_cnt[i] == DBW'(DB_CYC - 1)) begin
                  db[i]     <= ~db[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DBW'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

`ifdef TETRIS_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int unsigned RCW     = $clog2(REP_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_t;

   rep_state_t     rep_state     [2];
   rep_state_t     rep_state_nxt [2];
   logic [RCW-1:0] rep_cnt       [2];
   logic [RCW-1:0] rep_cnt_nxt   [2];

   // Auto-repeat state registers (left, right).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            rep_state[i] <= ST_IDLE;
            rep_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            rep_state[i] <= rep_state_nxt[i];
            rep_cnt[i]   <= rep_cnt_nxt[i];
         end
      end
   end

   // Auto-repeat next state; the press itself is handled by press_c, so
   // the FSM only contributes the delayed and periodic repeats.
   always_comb begin
      rep_set_c = '0;
      for (int i = 0; i < 2; i++) begin
         rep_state_nxt[i] = rep_state[i];
         rep_cnt_nxt[i]   = rep_cnt[i];
         if (!enable || !db[i]) begin
            rep_state_nxt[i] = ST_IDLE;
            rep_cnt_nxt[i]   = '0;
         end else begin
            case (rep_state[i])
               ST_IDLE: begin
                  if (press_c[i]) begin
                     rep_state_nxt[i] = ST_DELAY;
                     rep_cnt_nxt[i]   = '0;
                  end
               end
               ST_DELAY: begin
                  if (rep_cnt[i] == RCW'(REP_DELAY - 1)) begin
                     rep_state_nxt[i] = ST_REPEAT;
                     rep_cnt_nxt[i]   = '0;
                     rep_set_c[i]     = 1'b1;
                  end else begin
                     rep_cnt_nxt[i] = rep_cnt[i] + RCW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt[i] == RCW'(REP_PERIOD - 1)) begin
                     rep_cnt_nxt[i] = '0;
                     rep_set_c[i]   = 1'b1;
                  end else begin
                     rep_cnt_nxt[i] = rep_cnt[i] + RCW'(1);
                  end
               end
               default: begin
                  rep_state_nxt[i] = ST_IDLE;
                  rep_cnt_nxt[i]   = '0;
               end
            endcase
         end
      end
   end
`else
   assign rep_set_c = 2'b00;
`endif

   // Gravity period for the current level, floored at GRAV_MIN.
   logic [PW-1:0] step_prod_c;
   logic [PW-1:0] p_level_c;
   logic [PW-1:0] p_eff_c;
   logic          g_term_c;
   logic [PW-1:0] gcnt;
   logic [PW-1:0] p_lat;

   assign step_prod_c = PW'(GRAV_STEP) * PW'(level);

   always_comb begin
      p_level_c = PW'(GRAV_MIN);
      if (step_prod_c < PW'(GRAV_PERIOD0) &&
          (PW'(GRAV_PERIOD0) - step_prod_c) > PW'(GRAV_MIN))
         p_level_c = PW'(GRAV_PERIOD0) - step_prod_c;
   end

   // Holding down shortens the active period; >= catches a count already
   // past the shorter terminal when soft drop engages mid-period.
   assign p_eff_c  = (db[2] && p_lat > PW'(SOFT_PERIOD)) ? PW'(SOFT_PERIOD) : p_lat;
   assign g_term_c = (gcnt >= p_eff_c - PW'(1));

   logic          d_pend, l_pend, r_pend;
   logic          d_pend_nxt, l_pend_nxt, r_pend_nxt;
   logic [PW-1:0] gcnt_nxt;
   logic [PW-1:0] p_lat_nxt;
   logic          drop_nxt, left_nxt, right_nxt;

   // Move-generation state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt   <= '0;
         p_lat  <= PW'(GRAV_PERIOD0);
         d_pend <= 1'b0;
         l_pend <= 1'b0;
         r_pend <= 1'b0;
         drop   <= 1'b0;
         left   <= 1'b0;
         right  <= 1'b0;
      end else begin
         gcnt   <= gcnt_nxt;
         p_lat  <= p_lat_nxt;
         d_pend <= d_pend_nxt;
         l_pend <= l_pend_nxt;
         r_pend <= r_pend_nxt;
         drop   <= drop_nxt;
         left   <= left_nxt;
         right  <= right_nxt;
      end
   end

   // Gravity timer, pending flags and issue arbitration (drop > cancel > left > right).
   always_comb begin
      gcnt_nxt   = gcnt;
      p_lat_nxt  = p_lat;
      d_pend_nxt = d_pend;
      l_pend_nxt = l_pend;
      r_pend_nxt = r_pend;
      drop_nxt   = 1'b0;
      left_nxt   = 1'b0;
      right_nxt  = 1'b0;
      if (enable) begin
         if (g_term_c) begin
            gcnt_nxt  = '0;
            p_lat_nxt = p_level_c;
         end else begin
            gcnt_nxt = gcnt + PW'(1);
         end
         if (!busy) begin
            if (d_pend) begin
               drop_nxt   = 1'b1;
               d_pend_nxt = 1'b0;
            end else if (l_pend && r_pend) begin
               l_pend_nxt = 1'b0;
               r_pend_nxt = 1'b0;
            end else if (l_pend) begin
               left_nxt   = 1'b1;
               l_pend_nxt = 1'b0;
            end else if (r_pend) begin
               right_nxt  = 1'b1;
               r_pend_nxt = 1'b0;
            end
         end
         // New requests land after the clears so none is lost on an issue edge.
         if (g_term_c || press_c[2]) d_pend_nxt = 1'b1;
         if (press_c[2])             gcnt_nxt   = '0;
         if (press_c[0] || rep_set_c[0]) l_pend_nxt = 1'b1;
         if (press_c[1] || rep_set_c[1]) r_pend_nxt = 1'b1;
      end else begin
         gcnt_nxt   = '0;
         d_pend_nxt = 1'b0;
         l_pend_nxt = 1'b0;
         r_pend_nxt = 1'b0;
      end
   end

endmodule

// File: doc/tetris_move_gen.md
# tetris_move_gen

Move-request generator for the falling Tetris piece. It debounces the raw left, right and down buttons and runs the level-dependent gravity timer. It arbitrates both sources into single-cycle, mutually exclusive `drop` / `left` / `right` pulses. These pulses drive the downstream piece-position stage, which applies one move per pulse.

## Interface
- `DB_CYC`, 16: consecutive stable cycles required to accept a button change (≥2)
- `GRAV_PERIOD0`, 1024: gravity period in cycles at level 0
- `GRAV_STEP`, 64: period reduction per level
- `GRAV_MIN`, 64: gravity period floor
- `SOFT_PERIOD`, 32: drop period while down is held
- `REP_DELAY`, 128: cycles from press to first auto-repeat
- `REP_PERIOD`, 32: cycles between subsequent auto-repeats

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_left`  in  1  raw async button, active-high
- `btn_right`  in  1  raw async button, active-high
- `btn_down`  in  1  raw async button, active-high (soft drop)
- `level`  in  4  current game level, 0–15
- `enable`  in  1  game running; low freezes and flushes the block
- `busy`  in  1  downstream cannot accept a move this cycle
- `drop`  out  1  one-cycle pulse: move piece down one row
- `left`  out  1  one-cycle pulse: move piece left one column
- `right`  out  1  one-cycle pulse: move piece right one column

## Operation
- **Sync:** each button passes through a 2-FF synchronizer.
- **Debounce:** a per-button counter. The debounced level flips once the synchronized value has differed from it for `DB_CYC` consecutive edges. Any mismatch break resets the counter. A debounced 0→1 transition is a press event.
- **Pending flags:** `l_pend`, `r_pend`, `d_pend`. Events set a flag, issue clears it. Multiple events while a flag is pending coalesce into one.
- **Gravity:** counter `gcnt` counts 0..P−1 while `enable`. At P−1 it sets `d_pend` and wraps to 0.
  - P = max(`GRAV_MIN`, `GRAV_PERIOD0` − `level`·`GRAV_STEP`), computed at ≥16-bit width with no underflow.
  - P is latched at the wrap, so a level change takes effect from the next period.
  - While debounced down is held, P = min(latched P, `SOFT_PERIOD`).
- **Soft-drop press event:** sets `d_pend` immediately and resets `gcnt` to 0.
- **Issue (registered outputs), evaluated each edge when `busy`=0 and `enable`=1:**
  - If `d_pend`: pulse `drop` and clear `d_pend`.
  - Else if `l_pend` and `r_pend`: clear both and pulse nothing (opposing requests cancel).
  - Else if `l_pend`: pulse `left`.
  - Else if `r_pend`: pulse `right`.
  - At most one output is high in any cycle. While `busy`=1, nothing issues and flags hold.
- **`enable`=0:**
  - All pending flags, `gcnt`, repeat FSMs and outputs are cleared and held.
  - Debouncers keep running, so a button held across the enable rise does not generate a press event.
- **Reset:** all outputs 0, flags 0, `gcnt` 0, latched P = `GRAV_PERIOD0`. Debounced levels are 0 and synchronizers are 0. Reset may assert mid-operation and clears everything immediately.

## Timing
- Button latency (busy=0): raw high first sampled at edge 1 → debounced high at edge `DB_CYC`+2 → pend at edge `DB_CYC`+3 → output pulse high after edge `DB_CYC`+4, for exactly one cycle.
- A pend set while `busy`=1 issues on the first edge after `busy` is sampled low.
- Gravity with constant P and no busy: `drop` pulses are exactly P cycles apart.
- A gravity terminal count and a soft-drop press on the same edge produce one pending drop.

## Configuration
- `TETRIS_AUTOREPEAT_EN` defined:
  - Left and right each have an FSM: IDLE → (press) DELAY → REPEAT → (release) IDLE.
  - The press sets pend. DELAY sets pend after `REP_DELAY` cycles. REPEAT sets pend every `REP_PERIOD` cycles.
  - Debounced release returns the FSM to IDLE from any state.
- Undefined: exactly one pend per press. The FSMs and `REP_*` parameters are unused and no repeat logic is synthesized.

## Test plan
- Reset, `enable`=1, level 0, no buttons → first `drop` after 1024 cycles, then every 1024; `left`/`right` stay 0.
- `btn_left` raw high at edge 1, `busy`=0 → single `left` pulse after edge 20 (DB_CYC=16). A 10-cycle glitch on `btn_right` → no `right`.
- Level 15 → P = max(64, 1024−960) = 64, taking effect after the current period. `btn_down` held → first drop at press, then every 32 cycles.
- Left and right pressed within the same pending window, `busy`=1 throughout, gravity drop pending → on `busy` low, one `drop`, then nothing; both flags cleared.
- `enable` low mid-period with pends set → all outputs 0, no pulse on re-enable until a new event. `rst_n` pulsed low mid-debounce → all state 0 immediately.
- With `TETRIS_AUTOREPEAT_EN`, left held 400 cycles past debounce → pulses at press +0, +128, +160, +192, …; release → pulses stop. Without the macro → exactly one pulse.
